instr_prefetch_unit: RTL

Instruction prefetcher between the instruction memory port and the fetch stage of the pipelined core. Issues word-addressed reads ahead of the fetch stage, buffers returned words with their PC in a small in-order queue, and hands them to fetch under a valid/ready handshake. Redirects from the memory stage (taken branch) flush the queue, restart fetch at the branch target, and drop responses still in flight.

---
 rtl/instr_prefetch_unit_pkg.sv | 13 +
 rtl/prefetch_fifo.sv | 57 +++++
 rtl/instr_prefetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/instr_prefetch_unit_pkg.sv
// Shared types and default widths for the instruction prefetcher.
package instr_prefetch_unit_pkg;

    localparam int unsigned DEFAULT_PC_W    = 32;
    localparam int unsigned DEFAULT_INSTR_W = 32;
    localparam int unsigned DEFAULT_DEPTH   = 4;

    typedef struct packed {
        logic [DEFAULT_PC_W-1:0]    pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } prefetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// In-order DEPTH-entry queue of prefetched {pc, instr} entries; head is read from registered storage.
module prefetch_fifo
    import instr_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter type         entry_t = prefetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop & (count_q != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetcher: issues reads ahead of fetch, queues returned words with their PC,
// and on a taken-branch redirect flushes the queue and discards responses from the old path.
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int unsigned PC_W    = DEFAULT_PC_W,
    parameter int unsigned INSTR_W = DEFAULT_INSTR_W,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ready_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    input  logic               ready_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]  fpc_q, fpc_d;
    logic [PC_W-1:0]  rpc_q, rpc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   inflight;
    logic             accept, rsp, discard, push, pop;
    entry_t           push_data, head;

    // Every outstanding request owns a queue slot, so a response can always be pushed.
    assign inflight    = {1'b0, fifo_count} + {1'b0, out_cnt_q};
    assign imem_req_o  = reset & ~redirect_i & (inflight < (CNT_W + 1)'(DEPTH));
    assign imem_addr_o = fpc_q;
    assign accept      = imem_req_o & imem_ready_i;

    // Responses with nothing outstanding are protocol violations and are ignored.
    assign rsp     = imem_rvalid_i & (out_cnt_q != '0);
    assign discard = rsp & (redirect_i | (drop_cnt_q != '0));
    assign push    = rsp & ~discard;

    assign push_data = '{pc: rpc_q, instr: imem_rdata_i};

    assign valid_o = (fifo_count != '0) & ~redirect_i;
    assign pop     = valid_o & ready_i;
    assign instr_o = head.instr;
    assign pc_o    = head.pc;

    always_comb begin
        fpc_d      = fpc_q;
        rpc_d      = rpc_q;
        drop_cnt_d = drop_cnt_q;
        out_cnt_d  = out_cnt_q + CNT_W'(accept) - CNT_W'(rsp);
        if (redirect_i) begin
            fpc_d      = redirect_pc_i;
            rpc_d      = redirect_pc_i;
            drop_cnt_d = out_cnt_q - CNT_W'(rsp);
        end else begin
            if (accept) begin
                fpc_d = fpc_q + 1'b1;
            end
            if (push) begin
                rpc_d = rpc_q + 1'b1;
            end
            if (rsp && drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q      <= '0;
            rpc_q      <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            fpc_q      <= fpc_d;
            rpc_q      <= rpc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    prefetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule
